// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry and FSM encoding for the MEM-stage data cache
package cache_pkg;
  localparam int LINES = 32;
  localparam int IDX_W = 5;
  localparam int TAG_W = 30 - IDX_W;
  typedef enum logic [1:0] {IDLE = 2'd0, WBACK = 2'd1, FILL = 2'd2} state_t;
endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: pipeline-side and memory-side signals of the data cache
interface dcache_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic [31:0] miss_count;
  modport slave (
    input  mem_read, mem_write, addr, wdata, ext_ack, ext_rdata,
    output rdata, stall, ext_req, ext_we, ext_addr, ext_wdata, miss_count
  );
  modport master (
    output mem_read, mem_write, addr, wdata, ext_ack, ext_rdata,
    input  rdata, stall, ext_req, ext_we, ext_addr, ext_wdata, miss_count
  );
endinterface

// File: rtl/dcache_array.sv
// dcache_array: data/tag storage plus valid/dirty bits; async read, sync write
module dcache_array #(
  parameter int LINES = cache_pkg::LINES,
  parameter int IDX_W = cache_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_we,
  input  logic [31:0]       i_wdata,
  input  logic [29-IDX_W:0] i_wtag,
  input  logic              i_wdirty,
  input  logic              i_clr_dirty,
  output logic [31:0]       o_data,
  output logic [29-IDX_W:0] o_tag,
  output logic              o_valid,
  output logic              o_dirty
);
  logic [31:0]       r_data [LINES];
  logic [29-IDX_W:0] r_tag  [LINES];
  logic [LINES-1:0]  r_valid, r_dirty;
  always_ff @(posedge clk)
    if (i_we) begin
      r_data[i_idx] <= i_wdata;
      r_tag[i_idx]  <= i_wtag;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= i_wdirty;
    end else if (i_clr_dirty) begin
      r_dirty[i_idx] <= 1'b0;
    end
  assign o_data  = r_data[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back/write-allocate D-cache and miss FSM.
// The access inputs are held by the stalled pipeline, so they are never latched.
module dcache_ctrl #(
  parameter int LINES = cache_pkg::LINES,
  parameter int IDX_W = cache_pkg::IDX_W
) (
  input logic          clk,
  input logic          rst,
  dcache_ctrl_if.slave bus
);
  import cache_pkg::*;
  localparam int TW = 30 - IDX_W;
  state_t           r_state, w_next;
  logic [IDX_W-1:0] w_idx;
  logic [TW-1:0]    w_tag, w_vtag;
  logic [31:0]      w_vdata, w_wdata;
  logic             w_valid, w_vdirty, w_hit, w_miss, w_evict, w_ack;
  logic             w_we, w_wdirty, w_clr, w_stall;
  logic             r_req, r_we;
  logic [31:0]      r_addr, r_wdata, r_miss_count;
  assign w_idx   = bus.addr[IDX_W+1:2];
  assign w_tag   = bus.addr[31:IDX_W+2];
  assign w_hit   = w_valid && w_vtag == w_tag;
  assign w_miss  = r_state == IDLE && (bus.mem_read || bus.mem_write) && !w_hit;
  assign w_evict = w_valid && w_vdirty;
  assign w_ack   = bus.ext_ack && r_req;
  dcache_array #(.LINES(LINES), .IDX_W(IDX_W)) u_array (
    .clk(clk), .rst(rst), .i_idx(w_idx),
    .i_we(w_we), .i_wdata(w_wdata), .i_wtag(w_tag), .i_wdirty(w_wdirty), .i_clr_dirty(w_clr),
    .o_data(w_vdata), .o_tag(w_vtag), .o_valid(w_valid), .o_dirty(w_vdirty)
  );
  always_comb begin
    w_next   = r_state;
    w_stall  = 1'b1;
    w_we     = 1'b0;
    w_wdata  = bus.wdata;
    w_wdirty = 1'b1;
    w_clr    = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_miss;
        w_we    = bus.mem_write && w_hit;
        w_next  = !w_miss ? IDLE : w_evict ? WBACK : FILL;
      end
      WBACK: begin
        w_clr  = w_ack;
        w_next = w_ack ? FILL : WBACK;
      end
      default: begin
        w_we     = w_ack;
        w_wdata  = bus.ext_rdata;
        w_wdirty = 1'b0;
        w_next   = w_ack ? IDLE : FILL;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) begin
        r_miss_count <= r_miss_count + 32'd1;
        r_req        <= 1'b1;
        r_we         <= w_evict;
        r_addr       <= {w_evict ? w_vtag : w_tag, w_idx, 2'b00};
        r_wdata      <= w_vdata;
      end else if (r_state == WBACK && w_ack) begin
        r_we   <= 1'b0;
        r_addr <= {w_tag, w_idx, 2'b00};
      end else if (r_state == FILL && w_ack) begin
        r_req <= 1'b0;
      end
    end
  assign bus.rdata      = w_vdata;
  assign bus.stall      = w_stall;
  assign bus.ext_req    = r_req;
  assign bus.ext_we     = r_we;
  assign bus.ext_addr   = r_addr;
  assign bus.ext_wdata  = r_wdata;
  assign bus.miss_count = r_miss_count;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scoreboard bench; the bench plays the slow data memory
module tb_dcache_ctrl;
  typedef struct packed {logic we; logic [31:0] a; logic [31:0] d;} req_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dcache_ctrl_if bus ();
  dcache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  req_t        exp_reqs [$];
  logic [31:0] exp_rd [$];
  logic [31:0] cpu_mem [logic [31:0]];
  logic [31:0] ext_mem [logic [31:0]];
  int n_vec = 0;
  int n_err = 0;
  function automatic logic [31:0] init_val(logic [31:0] a);
    return a == 32'h40 ? 32'hDEADBEEF : a ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] cpu_val(logic [31:0] a);
    return cpu_mem.exists(a) ? cpu_mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ext_val(logic [31:0] a);
    return ext_mem.exists(a) ? ext_mem[a] : init_val(a);
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_reqs.push_back({we, a, d});
  endtask
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int dly, input int exp_stall, input logic chk_old, input logic [31:0] old);
    int stalls = 0;
    int w = 0;
    logic busy = 1'b0;
    logic [31:0] cap = '0;
    req_t e;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = d;
    if (rd) exp_rd.push_back(cpu_val(a));
    #1;
    while (bus.stall && stalls < 100) begin
      stalls++;
      bus.ext_ack = 1'b0;
      if (chk_old) check("no_early_write", bus.rdata, old);
      if (bus.ext_req) begin
        if (!busy) begin
          busy = 1'b1;
          w    = 0;
          cap  = bus.ext_addr;
          e    = exp_reqs.size() > 0 ? exp_reqs.pop_front() : '1;
          check("req_we", 32'(bus.ext_we), 32'(e.we));
          check("req_addr", bus.ext_addr, e.a);
          if (e.we) check("req_wdata", bus.ext_wdata, e.d);
        end else begin
          check("req_addr_hold", bus.ext_addr, cap);
        end
        if (w == dly) begin
          bus.ext_ack   = 1'b1;
          bus.ext_rdata = bus.ext_we ? 32'h0 : ext_val(cap);
          if (bus.ext_we) ext_mem[cap] = bus.ext_wdata;
          busy = 1'b0;
        end else begin
          w++;
        end
      end
      tick;
    end
    bus.ext_ack = 1'b0;
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
    check("reqs_consumed", 32'(exp_reqs.size()), 32'd0);
    if (rd) check("rdata", bus.rdata, exp_rd.pop_front());
    if (wr) cpu_mem[a] = d;
    tick;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask
  initial begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.ext_ack   = 1'b0;
    bus.ext_rdata = '0;
    tick;
    tick;
    check("rst_ext_req", 32'(bus.ext_req), 32'd0);
    check("rst_ext_we", 32'(bus.ext_we), 32'd0);
    check("rst_ext_addr", bus.ext_addr, 32'd0);
    check("rst_ext_wdata", bus.ext_wdata, 32'd0);
    check("rst_miss_count", bus.miss_count, 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;
    tick;
    // cold load, store hit, reload
    expect_req(1'b0, 32'h40, 32'h0);
    access(1'b1, 1'b0, 32'h40, 32'h0, 0, 2, 1'b0, 32'h0);
    check("cold_miss_count", bus.miss_count, 32'd1);
    access(1'b0, 1'b1, 32'h40, 32'h12345678, 0, 0, 1'b0, 32'h0);
    access(1'b1, 1'b0, 32'h40, 32'h0, 0, 0, 1'b0, 32'h0);
    check("hit_no_req", 32'(bus.ext_req), 32'd0);
    // dirty eviction of the same index
    expect_req(1'b1, 32'h40, 32'h12345678);
    expect_req(1'b0, 32'hC0, 32'h0);
    access(1'b1, 1'b0, 32'hC0, 32'h0, 0, 3, 1'b0, 32'h0);
    check("evict_miss_count", bus.miss_count, 32'd2);
    // slow memory: line must keep its old word until the fill ack
    expect_req(1'b0, 32'h140, 32'h0);
    access(1'b1, 1'b0, 32'h140, 32'h0, 5, 7, 1'b1, cpu_val(32'hC0));
    check("slow_miss_count", bus.miss_count, 32'd3);
    // reset in the middle of a fill
    bus.mem_read = 1'b1;
    bus.addr     = 32'h200;
    #1;
    check("fill_stall", 32'(bus.stall), 32'd1);
    tick;
    check("fill_req", 32'(bus.ext_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_req_drop", 32'(bus.ext_req), 32'd0);
    check("async_miss_clear", bus.miss_count, 32'd0);
    bus.mem_read = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    check("post_rst_stall", 32'(bus.stall), 32'd0);
    tick;
    expect_req(1'b0, 32'h200, 32'h0);
    access(1'b1, 1'b0, 32'h200, 32'h0, 0, 2, 1'b0, 32'h0);
    check("remiss_count", bus.miss_count, 32'd1);
    // stray ack with no request outstanding
    bus.ext_ack   = 1'b1;
    bus.ext_rdata = 32'hBAD0BAD0;
    tick;
    bus.ext_ack = 1'b0;
    #1;
    check("stray_miss_count", bus.miss_count, 32'd1);
    check("stray_req", 32'(bus.ext_req), 32'd0);
    check("stray_stall", 32'(bus.stall), 32'd0);
    tick;
    access(1'b1, 1'b0, 32'h200, 32'h0, 0, 0, 1'b0, 32'h0);
    // read+write together acts as store and shows the old word
    access(1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 0, 0, 1'b0, 32'h0);
    access(1'b1, 1'b0, 32'h200, 32'h0, 0, 0, 1'b0, 32'h0);
    // store miss over a dirty victim, then the written-back word comes back
    expect_req(1'b1, 32'h200, 32'hCAFEF00D);
    expect_req(1'b0, 32'h300, 32'h0);
    access(1'b0, 1'b1, 32'h300, 32'h0BADCAFE, 0, 3, 1'b0, 32'h0);
    access(1'b1, 1'b0, 32'h300, 32'h0, 0, 0, 1'b0, 32'h0);
    check("store_miss_count", bus.miss_count, 32'd2);
    expect_req(1'b1, 32'h300, 32'h0BADCAFE);
    expect_req(1'b0, 32'h200, 32'h0);
    access(1'b1, 1'b0, 32'h200, 32'h0, 1, 5, 1'b0, 32'h0);
    check("final_miss_count", bus.miss_count, 32'd3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
